// File: rtl/tx_arbiter_sequence_ctrl_pkg.sv
// Shared types for the TL TX arbiter sequencing controller: source codes,
// per-source slot indices, packing priority and grant FSM states.
package tx_arbiter_sequence_ctrl_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        A2P_1  = 3'd1,
        A2P_2  = 3'd2,
        MASTER = 3'd3,
        RX_CFG = 3'd4,
        RX_ERR = 3'd5
    } Tx_Arbiter_Sources_t;

    localparam int unsigned NUM_SRC = 4;

    // Bit positions of each source in the valid/pending/grant vectors
    localparam logic [1:0] SRC_A2P_1  = 2'd0;
    localparam logic [1:0] SRC_A2P_2  = 2'd1;
    localparam logic [1:0] SRC_MASTER = 2'd2;
    localparam logic [1:0] SRC_RX     = 2'd3;

    // Packing order, highest priority in the low two bits
    localparam logic [7:0] PRIO_ORDER = {SRC_A2P_2, SRC_A2P_1, SRC_MASTER, SRC_RX};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic Tx_Arbiter_Sources_t slot_to_src(input logic [1:0] slot, input logic rx_err);
        Tx_Arbiter_Sources_t src;
        case (slot)
            SRC_A2P_1:  src = A2P_1;
            SRC_A2P_2:  src = A2P_2;
            SRC_MASTER: src = MASTER;
            default:    src = rx_err ? RX_ERR : RX_CFG;
        endcase
        return src;
    endfunction

    function automatic logic [NUM_SRC-1:0] src_to_mask(input Tx_Arbiter_Sources_t src);
        logic [NUM_SRC-1:0] mask;
        mask = '0;
        case (src)
            A2P_1:          mask[SRC_A2P_1]  = 1'b1;
            A2P_2:          mask[SRC_A2P_2]  = 1'b1;
            MASTER:         mask[SRC_MASTER] = 1'b1;
            RX_CFG, RX_ERR: mask[SRC_RX]     = 1'b1;
            default:        mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tx_arbiter_req_packer.sv
// Combinational packer: turns the pending-source set and the free space into
// an ordered group of up to four recorder entries.
module tx_arbiter_req_packer
    import tx_arbiter_sequence_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic [NUM_SRC-1:0]  pending,
    input  logic                rx_err,
    input  logic [ADDR_WIDTH:0] available,
    output logic [2:0]          wr_count,
    output logic [2:0]          wr_mode,
    output logic [NUM_SRC-1:0]  taken,
    output Tx_Arbiter_Sources_t wr_data_1,
    output Tx_Arbiter_Sources_t wr_data_2,
    output Tx_Arbiter_Sources_t wr_data_3,
    output Tx_Arbiter_Sources_t wr_data_4
);

    Tx_Arbiter_Sources_t slots [4];
    logic [2:0]          limit;
    logic [1:0]          idx;

    always_comb begin
        limit    = (32'(available) >= 32'd4) ? 3'd4 : 3'(available);
        wr_count = 3'd0;
        taken    = '0;
        idx      = 2'd0;
        for (int s = 0; s < 4; s++) slots[s] = NONE;
        for (int i = 0; i < 4; i++) begin
            idx = PRIO_ORDER[2*i +: 2];
            if (pending[idx] && (wr_count < limit)) begin
                slots[wr_count[1:0]] = slot_to_src(idx, rx_err);
                taken[idx]           = 1'b1;
                wr_count             = wr_count + 3'd1;
            end
        end
        wr_mode = (wr_count != 3'd0) ? wr_count - 3'd1 : 3'd0;
    end

    assign wr_data_1 = slots[0];
    assign wr_data_2 = slots[1];
    assign wr_data_3 = slots[2];
    assign wr_data_4 = slots[3];

endmodule

// File: rtl/tx_arbiter_sequence_ctrl.sv
// TL TX arbiter sequencing: records request edges in arrival order and grants
// sources one at a time from the recorder head. Optional grant watchdog: TX_ARB_GRANT_TIMEOUT_EN.
module tx_arbiter_sequence_ctrl
    import tx_arbiter_sequence_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
`ifdef TX_ARB_GRANT_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                a2p_1_valid,
    input  logic                a2p_2_valid,
    input  logic                master_valid,
    input  logic [1:0]          rx_router_valid,
    output logic                a2p_1_grant,
    output logic                a2p_2_grant,
    output logic                master_grant,
    output logic                rx_router_grant,
    output logic                seq_wr_en,
    output logic [2:0]          seq_wr_mode,
    output Tx_Arbiter_Sources_t seq_wr_data_1,
    output Tx_Arbiter_Sources_t seq_wr_data_2,
    output Tx_Arbiter_Sources_t seq_wr_data_3,
    output Tx_Arbiter_Sources_t seq_wr_data_4,
    output logic                seq_rd_en,
    input  Tx_Arbiter_Sources_t seq_rd_data,
    input  logic [ADDR_WIDTH:0] seq_available,
    input  logic                seq_empty
`ifdef TX_ARB_GRANT_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    logic [NUM_SRC-1:0]  valid_vec, hist_q, pend_q, edge_vec, pend_comb, taken;
    logic [NUM_SRC-1:0]  grant_q, active_mask;
    logic                rx_err_q, rx_err_comb, active_valid;
    logic [ADDR_WIDTH:0] inflight, avail_eff;
    logic [2:0]          pk_count, pk_mode;
    Tx_Arbiter_Sources_t pk_d1, pk_d2, pk_d3, pk_d4, active_src;
    arb_state_t          state;

    assign valid_vec   = {rx_router_valid[1], master_valid, a2p_2_valid, a2p_1_valid};
    assign edge_vec    = valid_vec & ~hist_q;
    assign pend_comb   = pend_q | edge_vec;
    assign rx_err_comb = edge_vec[SRC_RX] ? rx_router_valid[0] : rx_err_q;

    // The recorder only reflects our registered write a cycle later, so the
    // entries still in flight are taken off the reported free space.
    assign inflight  = seq_wr_en ? (ADDR_WIDTH+1)'(seq_wr_mode) + (ADDR_WIDTH+1)'(1) : '0;
    assign avail_eff = (seq_available > inflight) ? seq_available - inflight : '0;

    assign active_mask  = src_to_mask(active_src);
    assign active_valid = |(valid_vec & active_mask);

`ifdef TX_ARB_GRANT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic [NUM_SRC-1:0] tmo_force;

    assign tmo_hit   = (state == ST_GRANT) && active_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_force = tmo_hit ? active_mask : '0;
`endif

    tx_arbiter_req_packer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_packer (
        .pending   (pend_comb),
        .rx_err    (rx_err_comb),
        .available (avail_eff),
        .wr_count  (pk_count),
        .wr_mode   (pk_mode),
        .taken     (taken),
        .wr_data_1 (pk_d1),
        .wr_data_2 (pk_d2),
        .wr_data_3 (pk_d3),
        .wr_data_4 (pk_d4)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            hist_q        <= '0;
            pend_q        <= '0;
            rx_err_q      <= 1'b0;
            seq_wr_en     <= 1'b0;
            seq_wr_mode   <= 3'd0;
            seq_wr_data_1 <= NONE;
            seq_wr_data_2 <= NONE;
            seq_wr_data_3 <= NONE;
            seq_wr_data_4 <= NONE;
        end else begin
`ifdef TX_ARB_GRANT_TIMEOUT_EN
            hist_q        <= valid_vec | tmo_force;
`else
            hist_q        <= valid_vec;
`endif
            pend_q        <= pend_comb & ~taken;
            rx_err_q      <= rx_err_comb;
            seq_wr_en     <= (pk_count != 3'd0);
            seq_wr_mode   <= pk_mode;
            seq_wr_data_1 <= pk_d1;
            seq_wr_data_2 <= pk_d2;
            seq_wr_data_3 <= pk_d3;
            seq_wr_data_4 <= pk_d4;
        end
    end

    // Grant FSM: pop the head in IDLE, hold the grant until that source drops
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= ST_IDLE;
            active_src  <= NONE;
            grant_q     <= '0;
            seq_rd_en   <= 1'b0;
`ifdef TX_ARB_GRANT_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            seq_rd_en <= 1'b0;
`ifdef TX_ARB_GRANT_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!seq_empty) begin
                        seq_rd_en  <= 1'b1;
                        active_src <= seq_rd_data;
                        grant_q    <= src_to_mask(seq_rd_data);
                        state      <= ST_GRANT;
`ifdef TX_ARB_GRANT_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!active_valid) begin
                        grant_q <= '0;
                        state   <= ST_IDLE;
                    end
`ifdef TX_ARB_GRANT_TIMEOUT_EN
                    else if (tmo_hit) begin
                        grant_q     <= '0;
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign a2p_1_grant     = grant_q[SRC_A2P_1];
    assign a2p_2_grant     = grant_q[SRC_A2P_2];
    assign master_grant    = grant_q[SRC_MASTER];
    assign rx_router_grant = grant_q[SRC_RX];

endmodule

// File: tb/tb_tx_arbiter_sequence_ctrl.sv
// Scoreboard bench for tx_arbiter_sequence_ctrl with a behavioural recorder FIFO.
// Define TX_ARB_GRANT_TIMEOUT_EN to also exercise the grant watchdog.
module tb_tx_arbiter_sequence_ctrl;
    import tx_arbiter_sequence_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic arst;
    logic a2p_1_valid, a2p_2_valid, master_valid;
    logic [1:0] rx_router_valid;
    logic a2p_1_grant, a2p_2_grant, master_grant, rx_router_grant;
    logic seq_wr_en, seq_rd_en, seq_empty;
    logic [2:0] seq_wr_mode;
    Tx_Arbiter_Sources_t seq_wr_data_1, seq_wr_data_2, seq_wr_data_3, seq_wr_data_4, seq_rd_data;
    logic [AW:0] seq_available;
`ifdef TX_ARB_GRANT_TIMEOUT_EN
    logic timeout_err;
`endif

    always #5 clk = ~clk;

    tx_arbiter_sequence_ctrl #(
        .FIFO_DEPTH      (DEPTH)
`ifdef TX_ARB_GRANT_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .a2p_1_valid     (a2p_1_valid),
        .a2p_2_valid     (a2p_2_valid),
        .master_valid    (master_valid),
        .rx_router_valid (rx_router_valid),
        .a2p_1_grant     (a2p_1_grant),
        .a2p_2_grant     (a2p_2_grant),
        .master_grant    (master_grant),
        .rx_router_grant (rx_router_grant),
        .seq_wr_en       (seq_wr_en),
        .seq_wr_mode     (seq_wr_mode),
        .seq_wr_data_1   (seq_wr_data_1),
        .seq_wr_data_2   (seq_wr_data_2),
        .seq_wr_data_3   (seq_wr_data_3),
        .seq_wr_data_4   (seq_wr_data_4),
        .seq_rd_en       (seq_rd_en),
        .seq_rd_data     (seq_rd_data),
        .seq_available   (seq_available),
        .seq_empty       (seq_empty)
`ifdef TX_ARB_GRANT_TIMEOUT_EN
        , .timeout_err   (timeout_err)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] wr_word(input logic [2:0] mode, input Tx_Arbiter_Sources_t a,
                                            input Tx_Arbiter_Sources_t b, input Tx_Arbiter_Sources_t c,
                                            input Tx_Arbiter_Sources_t d);
        return {mode, a, b, c, d};
    endfunction

    // Behavioural sequence recorder, show-ahead, capacity adjustable by the bench
    Tx_Arbiter_Sources_t mem [8];
    logic [2:0] wp, rp;
    logic [3:0] cnt, wr_n;
    logic       rd_n;
    int         cap;

    assign wr_n          = seq_wr_en ? 4'(seq_wr_mode) + 4'd1 : 4'd0;
    assign rd_n          = seq_rd_en && (cnt != 4'd0);
    assign seq_rd_data   = mem[rp];
    assign seq_empty     = (cnt == 4'd0);
    assign seq_available = 4'(cap) - cnt;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            wp  <= 3'd0;
            rp  <= 3'd0;
            cnt <= 4'd0;
        end else begin
            if (seq_wr_en) begin
                mem[wp] <= seq_wr_data_1;
                if (seq_wr_mode >= 3'd1) mem[wp + 3'd1] <= seq_wr_data_2;
                if (seq_wr_mode >= 3'd2) mem[wp + 3'd2] <= seq_wr_data_3;
                if (seq_wr_mode >= 3'd3) mem[wp + 3'd3] <= seq_wr_data_4;
            end
            wp  <= wp + wr_n[2:0];
            rp  <= rp + {2'b0, rd_n};
            cnt <= cnt + wr_n - {3'b0, rd_n};
        end
    end

    // Scoreboard: expectations are queued by the stimulus, consumed by the monitor
    logic [14:0] exp_wr [$];
    logic [3:0]  exp_gnt [$];
    logic [3:0]  gvec;
    logic [3:0]  gprev = 4'd0;

    assign gvec = {rx_router_grant, master_grant, a2p_2_grant, a2p_1_grant};

    always @(negedge clk) begin
        if (arst) begin
            if (seq_wr_en) begin
                check("wr_fit", 32'((cnt + wr_n) <= 4'(cap)), 32'd1);
                if (exp_wr.size() == 0)
                    check("wr_unexpected", {17'd0, seq_wr_en, wr_word(seq_wr_mode, seq_wr_data_1,
                          seq_wr_data_2, seq_wr_data_3, seq_wr_data_4)}, 32'd0);
                else
                    check("wr_entry", 32'(wr_word(seq_wr_mode, seq_wr_data_1, seq_wr_data_2,
                          seq_wr_data_3, seq_wr_data_4)), 32'(exp_wr.pop_front()));
            end
            if (gvec != gprev && gvec != 4'd0) begin
                check("gnt_gap", 32'(gprev), 32'd0);
                check("gnt_onehot", 32'($onehot(gvec)), 32'd1);
                check("gnt_rd_en", 32'(seq_rd_en), 32'd1);
                if (exp_gnt.size() == 0)
                    check("gnt_unexpected", 32'(gvec), 32'd0);
                else
                    check("gnt_order", 32'(gvec), 32'(exp_gnt.pop_front()));
            end
        end
        gprev = gvec;
    end

    task automatic drive_valid(input logic [3:0] vec, input logic level, input logic rx_err);
        if (vec[0]) a2p_1_valid  = level;
        if (vec[1]) a2p_2_valid  = level;
        if (vec[2]) master_valid = level;
        if (vec[3]) rx_router_valid = level ? {1'b1, rx_err} : 2'b01;
    endtask

    task automatic wait_grant(input logic [3:0] vec);
        int n;
        n = 0;
        @(negedge clk);
        while (gvec != vec && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("gnt_wait", 32'(gvec), 32'(vec));
    endtask

    // Wait for the grant, hold a while, drop the valid and check the release timing
    task automatic serve(input logic [3:0] vec);
        wait_grant(vec);
        repeat (3) begin
            @(negedge clk);
            check("gnt_hold", 32'(gvec), 32'(vec));
        end
        @(posedge clk);
        #1 drive_valid(vec, 1'b0, 1'b0);
        @(negedge clk);
        check("gnt_rel_same", 32'(gvec), 32'(vec));
        @(negedge clk);
        check("gnt_rel_drop", 32'(gvec), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b0;
        a2p_1_valid = 1'b0;
        a2p_2_valid = 1'b0;
        master_valid = 1'b0;
        rx_router_valid = 2'b00;
        cap = DEPTH;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grants", 32'(gvec), 32'd0);
        check("rst_wr_en", 32'(seq_wr_en), 32'd0);
        check("rst_wr_mode", 32'(seq_wr_mode), 32'd0);
        check("rst_wr_data", 32'(wr_word(3'd0, seq_wr_data_1, seq_wr_data_2, seq_wr_data_3, seq_wr_data_4)), 32'd0);
        check("rst_rd_en", 32'(seq_rd_en), 32'd0);
        arst = 1'b1;

        // Single A2P_1 request
        repeat (3) @(posedge clk);
        #1 a2p_1_valid = 1'b1;
        exp_wr.push_back(wr_word(3'd0, A2P_1, NONE, NONE, NONE));
        exp_gnt.push_back(4'b0001);
        @(negedge clk);
        check("t1_no_early_wr", 32'(seq_wr_en), 32'd0);
        @(negedge clk);
        check("t1_wr_latency", 32'(seq_wr_en), 32'd1);
        serve(4'b0001);

        // Four simultaneous edges, room for all
        repeat (3) @(posedge clk);
        #1 drive_valid(4'b1111, 1'b1, 1'b1);
        exp_wr.push_back(wr_word(3'd3, RX_ERR, MASTER, A2P_1, A2P_2));
        exp_gnt.push_back(4'b1000);
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0010);
        serve(4'b1000);
        serve(4'b0100);
        serve(4'b0001);
        serve(4'b0010);

        // Four simultaneous edges, recorder with two free slots
        repeat (3) @(posedge clk);
        cap = 2;
        #1 drive_valid(4'b1111, 1'b1, 1'b1);
        exp_wr.push_back(wr_word(3'd1, RX_ERR, MASTER, NONE, NONE));
        exp_wr.push_back(wr_word(3'd0, A2P_1, NONE, NONE, NONE));
        exp_wr.push_back(wr_word(3'd0, A2P_2, NONE, NONE, NONE));
        exp_gnt.push_back(4'b1000);
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0010);
        @(negedge clk);
        @(negedge clk);
        check("t3_first_wr", 32'(seq_wr_en), 32'd1);
        @(negedge clk);
        check("t3_full_no_wr_a", 32'(seq_wr_en), 32'd0);
        @(negedge clk);
        check("t3_full_no_wr_b", 32'(seq_wr_en), 32'd0);
        serve(4'b1000);
        serve(4'b0100);
        serve(4'b0001);
        serve(4'b0010);
        cap = DEPTH;

        // Rx Router CFG completion
        repeat (3) @(posedge clk);
        #1 rx_router_valid = 2'b10;
        exp_wr.push_back(wr_word(3'd0, RX_CFG, NONE, NONE, NONE));
        exp_gnt.push_back(4'b1000);
        serve(4'b1000);

        // Asynchronous reset during a master grant
        repeat (3) @(posedge clk);
        #1 master_valid = 1'b1;
        exp_wr.push_back(wr_word(3'd0, MASTER, NONE, NONE, NONE));
        exp_gnt.push_back(4'b0100);
        wait_grant(4'b0100);
        @(negedge clk);
        #2 arst = 1'b0;
        #1;
        check("arst_grants", 32'(gvec), 32'd0);
        check("arst_wr_en", 32'(seq_wr_en), 32'd0);
        check("arst_rd_en", 32'(seq_rd_en), 32'd0);
        check("arst_wr_data", 32'(wr_word(seq_wr_mode, seq_wr_data_1, seq_wr_data_2, seq_wr_data_3, seq_wr_data_4)), 32'd0);
        master_valid = 1'b0;
        a2p_2_valid  = 1'b1;
        repeat (2) @(posedge clk);
        exp_wr.push_back(wr_word(3'd0, A2P_2, NONE, NONE, NONE));
        exp_gnt.push_back(4'b0010);
        #1 arst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(gvec), 32'd0);
        check("post_rst_rd_en", 32'(seq_rd_en), 32'd0);
        serve(4'b0010);

`ifdef TX_ARB_GRANT_TIMEOUT_EN
        // Grant watchdog with a source that never lets go
        begin
            int hi;
            int pulses;
            repeat (3) @(posedge clk);
            #1 a2p_2_valid = 1'b1;
            exp_wr.push_back(wr_word(3'd0, A2P_2, NONE, NONE, NONE));
            exp_gnt.push_back(4'b0010);
            wait_grant(4'b0010);
            hi = 1;
            pulses = 0;
            repeat (40) begin
                @(negedge clk);
                if (gvec == 4'b0010) hi++;
                if (timeout_err) pulses++;
            end
            check("tmo_grant_len", 32'(hi), 32'd16);
            check("tmo_err_pulses", 32'(pulses), 32'd1);
            @(posedge clk);
            #1 a2p_2_valid = 1'b0;
        end
`endif

        repeat (6) @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
